// File: rtl/biriscv_bpred_pkg.sv
// Shared definitions for the biriscv branch predictor: BHT counter encoding, BTB entry layout
// and target type decoding.
package biriscv_bpred_pkg;

    localparam int unsigned BHT_CNT_W = 2;
    localparam logic [BHT_CNT_W-1:0] BHT_RESET = 2'b01;
    localparam logic [BHT_CNT_W-1:0] BHT_MAX   = 2'b11;

    localparam int unsigned BTB_TAG_W = 30;
    localparam int unsigned BTB_TGT_W = 30;

    typedef enum logic [1:0] {
        TgtBranch = 2'd0,
        TgtJmp    = 2'd1,
        TgtCall   = 2'd2,
        TgtRet    = 2'd3
    } tgt_type_e;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_TGT_W-1:0] target;
        logic                 is_call;
        logic                 is_ret;
        logic                 is_jmp;
    } btb_entry_t;

    // Return takes priority so a call+ret entry still uses the stack.
    function automatic tgt_type_e tgt_type(input logic is_call, input logic is_ret,
                                           input logic is_jmp);
        if (is_ret)       return TgtRet;
        else if (is_call) return TgtCall;
        else if (is_jmp)  return TgtJmp;
        else              return TgtBranch;
    endfunction

endpackage

// File: rtl/biriscv_bpred_ras.sv
// Non-speculative circular return address stack; a full stack overwrites its oldest entry.
module biriscv_bpred_ras
    import biriscv_bpred_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_addr,
    output logic [31:0] top_addr,
    output logic        valid
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] ptr_q, ptr_d, ptr_pop;
    logic [CW-1:0] cnt_q, cnt_d, cnt_pop;
    logic [31:0]   stack_q [RAS_DEPTH];

    // Pop is applied before push, so call+ret replaces the top entry.
    always_comb begin
        ptr_pop = ptr_q;
        cnt_pop = cnt_q;
        if (pop && (cnt_q != '0)) begin
            ptr_pop = ptr_q - PW'(1);
            cnt_pop = cnt_q - CW'(1);
        end
        ptr_d = ptr_pop;
        cnt_d = cnt_pop;
        if (push) begin
            ptr_d = ptr_pop + PW'(1);
            if (cnt_pop != CW'(RAS_DEPTH)) begin
                cnt_d = cnt_pop + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (push) begin
                stack_q[ptr_pop] <= push_addr;
            end
        end
    end

    assign top_addr = stack_q[ptr_q - PW'(1)];
    assign valid    = (cnt_q != '0);

endmodule

// File: rtl/biriscv_bpred.sv
// Fetch-stage branch predictor: BTB + 2-bit BHT + RAS, trained by resolved branches.
// Optional gshare indexing is enabled by defining BIRISCV_BPRED_GSHARE_EN.
module biriscv_bpred
    import biriscv_bpred_pkg::*;
#(
    parameter int unsigned NUM_BTB_ENTRIES = 16,
    parameter int unsigned NUM_BHT_ENTRIES = 256,
    parameter int unsigned RAS_DEPTH       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_request_i,
    input  logic        branch_is_taken_i,
    input  logic        branch_is_not_taken_i,
    input  logic [31:0] branch_source_i,
    input  logic [31:0] branch_pc_i,
    input  logic        branch_is_call_i,
    input  logic        branch_is_ret_i,
    input  logic        branch_is_jmp_i,
    input  logic [31:0] pc_f_i,
    input  logic        pc_accept_i,
    output logic [31:0] next_pc_f_o,
    output logic        next_taken_f_o
);

    localparam int unsigned BTB_W = $clog2(NUM_BTB_ENTRIES);
    localparam int unsigned BHT_W = $clog2(NUM_BHT_ENTRIES);

    btb_entry_t           btb_q [NUM_BTB_ENTRIES];
    logic [BHT_CNT_W-1:0] bht_q [NUM_BHT_ENTRIES];
    logic [BTB_W-1:0]     victim_q;
    logic [BHT_W-1:0]     ghr;

    logic             train_taken, train_not_taken;
    logic             hit_f, hit_t;
    logic [BTB_W-1:0] hit_idx_f, hit_idx_t;
    logic [BHT_W-1:0] bht_idx_f, bht_idx_t;
    btb_entry_t       new_entry;
    logic [31:0]      ras_top;
    logic             ras_valid;

    // Taken wins if both resolution flags are set.
    assign train_taken     = branch_request_i && branch_is_taken_i;
    assign train_not_taken = branch_request_i && !branch_is_taken_i && branch_is_not_taken_i;

`ifdef BIRISCV_BPRED_GSHARE_EN
    logic [BHT_W-1:0] ghr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (branch_request_i) begin
            ghr_q <= {ghr_q[BHT_W-2:0], branch_is_taken_i};
        end
    end

    assign ghr = ghr_q;
`else
    assign ghr = '0;
`endif

    assign bht_idx_f = pc_f_i[BHT_W+1:2] ^ ghr;
    assign bht_idx_t = branch_source_i[BHT_W+1:2] ^ ghr;

    // Lowest matching index wins on both the fetch and training ports.
    always_comb begin
        hit_f     = 1'b0;
        hit_idx_f = '0;
        hit_t     = 1'b0;
        hit_idx_t = '0;
        for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
            if (!hit_f && btb_q[i].valid && (btb_q[i].tag == pc_f_i[31:2])) begin
                hit_f     = 1'b1;
                hit_idx_f = BTB_W'(i);
            end
            if (!hit_t && btb_q[i].valid && (btb_q[i].tag == branch_source_i[31:2])) begin
                hit_t     = 1'b1;
                hit_idx_t = BTB_W'(i);
            end
        end
    end

    always_comb begin
        next_taken_f_o = 1'b0;
        next_pc_f_o    = pc_f_i + 32'd4;
        if (hit_f) begin
            case (tgt_type(btb_q[hit_idx_f].is_call, btb_q[hit_idx_f].is_ret,
                           btb_q[hit_idx_f].is_jmp))
                TgtRet: begin
                    next_taken_f_o = 1'b1;
                    next_pc_f_o    = ras_valid ? ras_top : {btb_q[hit_idx_f].target, 2'b00};
                end
                TgtJmp, TgtCall: begin
                    next_taken_f_o = 1'b1;
                    next_pc_f_o    = {btb_q[hit_idx_f].target, 2'b00};
                end
                default: begin
                    if (bht_q[bht_idx_f][1]) begin
                        next_taken_f_o = 1'b1;
                        next_pc_f_o    = {btb_q[hit_idx_f].target, 2'b00};
                    end
                end
            endcase
        end
    end

    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.tag     = branch_source_i[31:2];
        new_entry.target  = branch_pc_i[31:2];
        new_entry.is_call = branch_is_call_i;
        new_entry.is_ret  = branch_is_ret_i;
        new_entry.is_jmp  = branch_is_jmp_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BHT_ENTRIES; i++) begin
                bht_q[i] <= BHT_RESET;
            end
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
            victim_q <= '0;
        end else begin
            if (train_taken && (bht_q[bht_idx_t] != BHT_MAX)) begin
                bht_q[bht_idx_t] <= bht_q[bht_idx_t] + BHT_CNT_W'(1);
            end else if (train_not_taken && (bht_q[bht_idx_t] != '0)) begin
                bht_q[bht_idx_t] <= bht_q[bht_idx_t] - BHT_CNT_W'(1);
            end
            if (train_taken) begin
                if (hit_t) begin
                    btb_q[hit_idx_t] <= new_entry;
                end else begin
                    btb_q[victim_q] <= new_entry;
                    victim_q        <= victim_q + BTB_W'(1);
                end
            end
        end
    end

    biriscv_bpred_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (branch_request_i && branch_is_call_i),
        .pop       (branch_request_i && branch_is_ret_i),
        .push_addr (branch_source_i + 32'd4),
        .top_addr  (ras_top),
        .valid     (ras_valid)
    );

    // pc_accept_i is reserved for speculative history.
    logic unused_ok;
    assign unused_ok = ^{pc_accept_i, branch_pc_i[1:0]};

endmodule

// File: tb/tb_biriscv_bpred.sv
// Directed bench for biriscv_bpred with hand-computed next-PC predictions.
module tb_biriscv_bpred;

    logic        clk;
    logic        rst;
    logic        branch_request_i;
    logic        branch_is_taken_i;
    logic        branch_is_not_taken_i;
    logic [31:0] branch_source_i;
    logic [31:0] branch_pc_i;
    logic        branch_is_call_i;
    logic        branch_is_ret_i;
    logic        branch_is_jmp_i;
    logic [31:0] pc_f_i;
    logic        pc_accept_i;
    logic [31:0] next_pc_f_o;
    logic        next_taken_f_o;

    int n_checks = 0;
    int n_fail   = 0;

    biriscv_bpred u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .branch_request_i      (branch_request_i),
        .branch_is_taken_i     (branch_is_taken_i),
        .branch_is_not_taken_i (branch_is_not_taken_i),
        .branch_source_i       (branch_source_i),
        .branch_pc_i           (branch_pc_i),
        .branch_is_call_i      (branch_is_call_i),
        .branch_is_ret_i       (branch_is_ret_i),
        .branch_is_jmp_i       (branch_is_jmp_i),
        .pc_f_i                (pc_f_i),
        .pc_accept_i           (pc_accept_i),
        .next_pc_f_o           (next_pc_f_o),
        .next_taken_f_o        (next_taken_f_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_train(input logic [31:0] src, input logic [31:0] tgt, input logic tk,
                             input logic call, input logic ret, input logic jmp);
        branch_request_i      = 1'b1;
        branch_source_i       = src;
        branch_pc_i           = tgt;
        branch_is_taken_i     = tk;
        branch_is_not_taken_i = !tk;
        branch_is_call_i      = call;
        branch_is_ret_i       = ret;
        branch_is_jmp_i       = jmp;
    endtask

    task automatic clear_train();
        branch_request_i      = 1'b0;
        branch_is_taken_i     = 1'b0;
        branch_is_not_taken_i = 1'b0;
        branch_is_call_i      = 1'b0;
        branch_is_ret_i       = 1'b0;
        branch_is_jmp_i       = 1'b0;
    endtask

    task automatic train(input logic [31:0] src, input logic [31:0] tgt, input logic tk,
                         input logic call, input logic ret, input logic jmp);
        @(negedge clk);
        set_train(src, tgt, tk, call, ret, jmp);
        @(posedge clk);
        #1;
        clear_train();
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic [31:0] exp_pc,
                          input logic exp_tk);
        @(negedge clk);
        pc_f_i = pc;
        #1;
        check({tag, "_pc"}, next_pc_f_o, exp_pc);
        check({tag, "_tk"}, {31'd0, next_taken_f_o}, {31'd0, exp_tk});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        pc_f_i      = 32'h0;
        pc_accept_i = 1'b1;
        branch_source_i = 32'h0;
        branch_pc_i     = 32'h0;
        clear_train();
        do_reset();

        lookup("reset", 32'h8000_0000, 32'h8000_0004, 1'b0);
        lookup("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);

        // Training and lookup of the same source in one cycle: old state seen first
        @(negedge clk);
        pc_f_i = 32'h140;
        set_train(32'h140, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        check("same_cycle_pc", next_pc_f_o, 32'h144);
        check("same_cycle_tk", {31'd0, next_taken_f_o}, 32'd0);
        @(posedge clk);
        #1;
        clear_train();
        #1;
        check("next_cycle_pc", next_pc_f_o, 32'h40);
        check("next_cycle_tk", {31'd0, next_taken_f_o}, 32'd1);

`ifndef BIRISCV_BPRED_GSHARE_EN
        // Conditional branch: 01 -> 10 -> 11, then 11 -> 10 -> 01
        train(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        train(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        lookup("beq_taken", 32'h100, 32'h80, 1'b1);
        train(32'h100, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
        lookup("beq_weak_t", 32'h100, 32'h80, 1'b1);
        train(32'h100, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
        lookup("beq_nt", 32'h100, 32'h104, 1'b0);
`endif

        // Call / return
        train(32'h200, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0);
        lookup("call", 32'h200, 32'h400, 1'b1);
        train(32'h480, 32'h204, 1'b1, 1'b0, 1'b1, 1'b0);
        lookup("ret_empty", 32'h480, 32'h204, 1'b1);
        train(32'h300, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0);
        lookup("ret_ras", 32'h480, 32'h304, 1'b1);
        train(32'h480, 32'h204, 1'b1, 1'b0, 1'b1, 1'b0);
        lookup("ret_popped", 32'h480, 32'h204, 1'b1);

        // RAS overflow: 10 pushes into 8 slots, pops return newest first
        for (int i = 0; i < 10; i++) begin
            train(32'h1000 + 32'(i) * 32'h10, 32'h4000, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            lookup("ras_order", 32'h480, 32'h1004 + 32'(9 - k) * 32'h10, 1'b1);
            train(32'h480, 32'h204, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        lookup("ras_drained", 32'h480, 32'h204, 1'b1);
        train(32'h480, 32'h204, 1'b1, 1'b0, 1'b1, 1'b0);
        train(32'h300, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0);
        lookup("ras_no_underflow", 32'h480, 32'h304, 1'b1);

        // Reset coinciding with a training request discards it
        @(negedge clk);
        rst = 1'b1;
        set_train(32'h700, 32'h800, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        clear_train();
        @(negedge clk);
        rst = 1'b0;
        lookup("reset_discard", 32'h700, 32'h704, 1'b0);

        // BTB round-robin: 17 allocations evict entry 0
        for (int i = 0; i < 17; i++) begin
            train(32'h2000 + 32'(i) * 4, 32'h3000 + 32'(i) * 4, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        lookup("btb_evicted", 32'h2000, 32'h2004, 1'b0);
        for (int i = 1; i < 17; i++) begin
            lookup("btb_hit", 32'h2000 + 32'(i) * 4, 32'h3000 + 32'(i) * 4, 1'b1);
        end

`ifdef BIRISCV_BPRED_GSHARE_EN
        // Alternating T/NT: history 0xAA precedes T, 0x55 precedes NT once warmed up
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) train(32'h600, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0);
            else            train(32'h600, 32'h604, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        lookup("gshare_t", 32'h600, 32'h700, 1'b1);
        train(32'h600, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0);
        lookup("gshare_nt", 32'h600, 32'h604, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
